bmc_soft_pipe: RTL and testbench
================================

Name: bmc_soft_pipe

Overview:
- Parametrised branch metric computation (BMC) unit for the Viterbi decoder; next generation of the fixed K=3 hard-decision BMC blocks.
- Accepts one rate-1/2 received symbol pair per handshake, with soft or hard decisions and per-symbol erasure (puncturing).
- Produces the registered branch metrics for both branches of every trellis state, derived from generator polynomials.
- Sits between the depuncturer/demapper and the ACS array; valid/ready on both sides.

Parameters:
- SOFT_W, 3, bits per soft symbol, offset-binary: 0 = strong 0, SMAX = 2^SOFT_W-1 = strong 1. SOFT_W=1 gives hard decision.
- K, 3, constraint length. NS = 2^(K-1) states.
- G0, 3'b111, K-bit generator polynomial for code bit c0.
- G1, 3'b101, K-bit generator polynomial for code bit c1.
- CNT_W, 16, width of the accepted-symbol counter.
- Derived: BM_W = SOFT_W+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  rx_sym/erase valid
- in_ready  out  1  block can accept this cycle
- rx_sym  in  2*SOFT_W  [SOFT_W-1:0] = sym0 (pairs with c0), [2*SOFT_W-1:SOFT_W] = sym1 (pairs with c1)
- erase  in  2  bit i=1: symbol i punctured
- out_valid  out  1  bm_flat valid
- out_ready  in  1  ACS consumes bm_flat
- bm_flat  out  NS*2*BM_W  metric for state s, input bit b at bits [(2*s+b)*BM_W +: BM_W]
- sym_count  out  CNT_W  count of completed output handshakes

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0, bm_flat=0, sym_count=0, both pipeline stages empty. in_ready=0 while rst is high and 1 on the first cycle after.
- Expected code bits: r = {b, s[K-2:0]} (K bits, b at MSB); c0 = ^(r & G0); c1 = ^(r & G1).
- Symbol distance: d_i = rx_i if c_i=0; d_i = SMAX - rx_i if c_i=1; d_i = 0 if erase[i]=1.
- Branch metric: bm = d0 + d1, unsigned, BM_W bits. Range 0..2*SMAX; no saturation needed.
- Stage 1 (S1):
  - On input handshake (in_valid & in_ready), register the four distinct metrics m00, m01, m10, m11, indexed by {c0,c1}.
  - The subtraction/erase logic is entirely before S1; no combinational path from rx_sym to bm_flat.
- Stage 2 (S2): fan out m{c0c1} to every (s,b) slot of bm_flat using constant code-bit tables computed at elaboration. S2 drives bm_flat and out_valid.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high. Throughput: 1 symbol per cycle.
- Handshake rules:
  - in_ready = ~s1_v | ~s2_v | out_ready (combinational from out_ready is allowed).
  - S2 loads from S1 when S1 valid and (S2 empty or out_ready).
  - While out_valid & ~out_ready, bm_flat and out_valid hold stable.
  - No data dropped or duplicated under any valid/ready pattern.
- Simultaneous events: an output handshake and an input handshake in the same cycle both proceed; occupancy is unchanged.
- sym_count: increments on each out_valid & out_ready. Wraps from 2^CNT_W-1 to 0 and never saturates.
- Reset mid-operation: rst=1 empties both stages in one cycle regardless of handshakes. In-flight symbols are discarded and sym_count clears. rst overrides a coincident handshake.
- erase=2'b11: all metrics are 0; the symbol still occupies a slot and is counted.

Test Plan:
- Hard decision: SOFT_W=1, K=3, G=111/101, rx_sym=2'b11, erase=0 -> slot(s0,b0)=2, (s0,b1)=0, (s1,b0)=0, (s1,b1)=2, (s2,b0)=1. out_valid exactly 2 cycles after the handshake.
- Soft: SOFT_W=3, sym0=7, sym1=7 -> (s0,b0)=14, (s0,b1)=0, (s1,b0)=0, (s1,b1)=14, (s2,b0)=7.
- Erasure: sym0=7, sym1=7, erase=2'b01 -> (s0,b0)=7, (s0,b1)=0, (s2,b0)=7. With erase=2'b11 -> every slot 0, sym_count still increments.
- Backpressure: stream 5 distinct pairs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts, bm_flat holds stable. On release all 5 emerge in order, none lost or repeated, sym_count=5.
- Reset mid-stream: rst=1 for 1 cycle with both stages full -> next cycle out_valid=0, sym_count=0, in_ready=1. A new symbol after reset emerges 2 cycles later with correct metrics.
- Counter wrap: CNT_W=4, 17 output handshakes -> sym_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: two-stage branch metric unit for a rate-1/2 Viterbi decoder.
// Takes one received symbol pair per handshake, with soft/hard decisions and
// per-symbol erasure, and produces the metric for both branches of every state.
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : input handshake for rx_sym/erase
//   rx_sym         : {sym1, sym0}, offset-binary soft symbols
//   erase          : bit i set -> symbol i punctured (contributes 0)
//   out_valid/ready: output handshake for bm_flat
//   bm_flat        : slot (s,b) at bits [(2*s+b)*BM_W +: BM_W]
//   sym_count      : completed output handshakes, wrapping
module bmc_soft_pipe #(
    parameter int unsigned SOFT_W = 3,
    parameter int unsigned K      = 3,
    parameter logic [K-1:0] G0    = 3'b111,
    parameter logic [K-1:0] G1    = 3'b101,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned BM_W  = SOFT_W + 1,
    localparam int unsigned NS    = 2 ** (K - 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*SOFT_W-1:0]      rx_sym,
    input  logic [1:0]               erase,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NS*2*BM_W-1:0]     bm_flat,
    output logic [CNT_W-1:0]         sym_count
);

    localparam int unsigned   FLAT_W = NS * 2 * BM_W;
    localparam logic [BM_W-1:0] SMAX = BM_W'((1 << SOFT_W) - 1);

    // Expected {c0,c1} for state s taking input bit b; r = {b, s}.
    function automatic logic [1:0] code_bits(input int unsigned s, input int unsigned b);
        logic [K-1:0] r;
        r = K'(s) | (K'(b) << (K - 1));
        return {^(r & G0), ^(r & G1)};
    endfunction

    logic                  s1_v_q, s1_v_d;
    logic                  s2_v_q, s2_v_d;
    logic [BM_W-1:0]       m_q [4];
    logic [BM_W-1:0]       m_d [4];
    logic [FLAT_W-1:0]     bm_q, bm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [SOFT_W-1:0]     sym0_c, sym1_c;
    logic [BM_W-1:0]       d0_c [2];
    logic [BM_W-1:0]       d1_c [2];
    logic [FLAT_W-1:0]     fan_c;
    logic                  in_hs_c, out_hs_c, s2_load_c;

    assign sym0_c = rx_sym[SOFT_W-1:0];
    assign sym1_c = rx_sym[2*SOFT_W-1:SOFT_W];

    // Symbol distances, indexed by the expected code bit.
    always_comb begin
        d0_c[0] = erase[0] ? '0 : BM_W'(sym0_c);
        d0_c[1] = erase[0] ? '0 : SMAX - BM_W'(sym0_c);
        d1_c[0] = erase[1] ? '0 : BM_W'(sym1_c);
        d1_c[1] = erase[1] ? '0 : SMAX - BM_W'(sym1_c);
    end

    // Constant fan-out of the four distinct metrics into every (s,b) slot.
    for (genvar gs = 0; gs < NS; gs++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam logic [1:0] CB = code_bits(gs, gb);
            assign fan_c[(2*gs+gb)*BM_W +: BM_W] = m_q[CB];
        end
    end

    assign in_ready  = ~rst & (~s1_v_q | ~s2_v_q | out_ready);
    assign in_hs_c   = in_valid & in_ready;
    assign out_hs_c  = s2_v_q & out_ready;
    assign s2_load_c = s1_v_q & (~s2_v_q | out_ready);

    // Next-state for both stages and the counter.
    always_comb begin
        s1_v_d = in_hs_c | (s1_v_q & ~s2_load_c);
        m_d[0] = m_q[0];
        m_d[1] = m_q[1];
        m_d[2] = m_q[2];
        m_d[3] = m_q[3];
        if (in_hs_c) begin
            m_d[0] = d0_c[0] + d1_c[0];
            m_d[1] = d0_c[0] + d1_c[1];
            m_d[2] = d0_c[1] + d1_c[0];
            m_d[3] = d0_c[1] + d1_c[1];
        end
        s2_v_d = s2_load_c | (s2_v_q & ~out_ready);
        bm_d   = s2_load_c ? fan_c : bm_q;
        cnt_d  = out_hs_c ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            bm_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < 4; i++) m_q[i] <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            bm_q   <= bm_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 4; i++) m_q[i] <= m_d[i];
        end
    end

    assign out_valid = s2_v_q;
    assign bm_flat   = bm_q;
    assign sym_count = cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
module tb_bmc_soft_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Soft-decision instance: SOFT_W=3, CNT_W=4 (for the wrap test).
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  rx_sym;
    logic [1:0]  erase;
    logic [31:0] bm_flat;
    logic [3:0]  sym_count;

    bmc_soft_pipe #(.SOFT_W(3), .K(3), .G0(3'b111), .G1(3'b101), .CNT_W(4)) u_soft (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rx_sym(rx_sym), .erase(erase), .out_valid(out_valid),
        .out_ready(out_ready), .bm_flat(bm_flat), .sym_count(sym_count)
    );

    // Hard-decision instance: SOFT_W=1.
    logic        h_rst, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [1:0]  h_rx_sym;
    logic [1:0]  h_erase;
    logic [15:0] h_bm_flat;
    logic [15:0] h_sym_count;

    bmc_soft_pipe #(.SOFT_W(1), .K(3), .G0(3'b111), .G1(3'b101), .CNT_W(16)) u_hard (
        .clk(clk), .rst(h_rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .rx_sym(h_rx_sym), .erase(h_erase), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .bm_flat(h_bm_flat), .sym_count(h_sym_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sslot(input logic [31:0] v, input int s, input int b);
        return v[(2*s+b)*4 +: 4];
    endfunction

    function automatic logic [1:0] hslot(input logic [15:0] v, input int s, input int b);
        return v[(2*s+b)*2 +: 2];
    endfunction

    // Reference soft metrics for K=3, G=111/101, SOFT_W=3.
    function automatic logic [31:0] exp_bm(input logic [5:0] rx, input logic [1:0] er);
        logic [31:0] v;
        logic [2:0]  r;
        logic        c0, c1;
        int          d0, d1;
        v = '0;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 2; b++) begin
                r  = 3'(b * 4 + s);
                c0 = r[2] ^ r[1] ^ r[0];
                c1 = r[2] ^ r[0];
                d0 = er[0] ? 0 : (c0 ? 7 - int'(rx[2:0]) : int'(rx[2:0]));
                d1 = er[1] ? 0 : (c1 ? 7 - int'(rx[5:3]) : int'(rx[5:3]));
                v[(2*s+b)*4 +: 4] = 4'(d0 + d1);
            end
        end
        return v;
    endfunction

    // Present one symbol for a single (ready) cycle on the soft instance.
    task automatic send(input logic [5:0] rx, input logic [1:0] er);
        in_valid = 1'b1;
        rx_sym   = rx;
        erase    = er;
        step();
        in_valid = 1'b0;
    endtask

    logic [5:0]  pairs [5];
    logic [31:0] bm_hold;
    int          inidx, outidx, n_out;
    logic        hs_in, hs_out;

    initial begin
        pairs[0] = {3'd2, 3'd1};
        pairs[1] = {3'd4, 3'd3};
        pairs[2] = {3'd6, 3'd5};
        pairs[3] = {3'd7, 3'd0};
        pairs[4] = {3'd1, 3'd6};

        rst = 1'b1; in_valid = 1'b0; rx_sym = '0; erase = '0; out_ready = 1'b1;
        h_rst = 1'b1; h_in_valid = 1'b0; h_rx_sym = '0; h_erase = '0; h_out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; h_rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bm_flat", bm_flat, 32'd0);
        chk("rst_sym_count", 32'(sym_count), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Hard decision, rx=11.
        h_in_valid = 1'b1; h_rx_sym = 2'b11; h_erase = 2'b00;
        step();
        h_in_valid = 1'b0;
        chk("hard_lat1_valid", 32'(h_out_valid), 32'd0);
        step();
        chk("hard_lat2_valid", 32'(h_out_valid), 32'd1);
        chk("hard_s0b0", 32'(hslot(h_bm_flat, 0, 0)), 32'd2);
        chk("hard_s0b1", 32'(hslot(h_bm_flat, 0, 1)), 32'd0);
        chk("hard_s1b0", 32'(hslot(h_bm_flat, 1, 0)), 32'd0);
        chk("hard_s1b1", 32'(hslot(h_bm_flat, 1, 1)), 32'd2);
        chk("hard_s2b0", 32'(hslot(h_bm_flat, 2, 0)), 32'd1);
        step();
        chk("hard_count", 32'(h_sym_count), 32'd1);
        chk("hard_drain", 32'(h_out_valid), 32'd0);

        // Soft, 7/7.
        send({3'd7, 3'd7}, 2'b00);
        chk("soft_lat1_valid", 32'(out_valid), 32'd0);
        step();
        chk("soft_lat2_valid", 32'(out_valid), 32'd1);
        chk("soft_s0b0", 32'(sslot(bm_flat, 0, 0)), 32'd14);
        chk("soft_s0b1", 32'(sslot(bm_flat, 0, 1)), 32'd0);
        chk("soft_s1b0", 32'(sslot(bm_flat, 1, 0)), 32'd0);
        chk("soft_s1b1", 32'(sslot(bm_flat, 1, 1)), 32'd14);
        chk("soft_s2b0", 32'(sslot(bm_flat, 2, 0)), 32'd7);
        chk("soft_full", bm_flat, exp_bm({3'd7, 3'd7}, 2'b00));
        step();
        chk("soft_count", 32'(sym_count), 32'd1);

        // Erasure of sym0.
        send({3'd7, 3'd7}, 2'b01);
        step();
        chk("er01_s0b0", 32'(sslot(bm_flat, 0, 0)), 32'd7);
        chk("er01_s0b1", 32'(sslot(bm_flat, 0, 1)), 32'd0);
        chk("er01_s2b0", 32'(sslot(bm_flat, 2, 0)), 32'd7);
        chk("er01_full", bm_flat, exp_bm({3'd7, 3'd7}, 2'b01));
        step();

        // Both erased.
        send({3'd7, 3'd7}, 2'b11);
        step();
        chk("er11_valid", 32'(out_valid), 32'd1);
        chk("er11_zero", bm_flat, 32'd0);
        step();
        chk("er11_count", 32'(sym_count), 32'd3);

        // Backpressure: 5 pairs, out_ready low for the first 4 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        inidx = 0; outidx = 0; bm_hold = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (outidx == 5) break;
            out_ready = (cyc >= 4);
            in_valid  = (inidx < 5);
            rx_sym    = (inidx < 5) ? pairs[inidx] : 6'd0;
            erase     = 2'b00;
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(inidx), 32'd2);
                bm_hold = bm_flat;
            end
            if (cyc == 3) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_bm", bm_flat, bm_hold);
                chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            end
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out)
                chk($sformatf("bp_out%0d", outidx), bm_flat, exp_bm(pairs[outidx], 2'b00));
            step();
            if (hs_in) inidx++;
            if (hs_out) outidx++;
        end
        in_valid = 1'b0;
        chk("bp_out_total", 32'(outidx), 32'd5);
        chk("bp_count", 32'(sym_count), 32'd5);
        step();
        chk("bp_no_extra", 32'(out_valid), 32'd0);

        // Reset with both stages full and a coincident handshake attempt.
        out_ready = 1'b0;
        send(pairs[0], 2'b00);
        send(pairs[1], 2'b00);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b1; rx_sym = pairs[2]; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_count", 32'(sym_count), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        send({3'd7, 3'd7}, 2'b00);
        chk("mid_lat1", 32'(out_valid), 32'd0);
        step();
        chk("mid_lat2", 32'(out_valid), 32'd1);
        chk("mid_bm", bm_flat, exp_bm({3'd7, 3'd7}, 2'b00));
        step();
        chk("mid_count_after", 32'(sym_count), 32'd1);
        chk("mid_drain", 32'(out_valid), 32'd0);

        // Counter wrap with CNT_W=4.
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        inidx = 0; n_out = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (n_out == 17) break;
            in_valid = (inidx < 17);
            rx_sym   = 6'(inidx);
            erase    = 2'b00;
            #1;
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            step();
            if (hs_in) inidx++;
            if (hs_out) begin
                n_out++;
                if (n_out >= 15)
                    chk($sformatf("wrap_%0d", n_out), 32'(sym_count), 32'(n_out % 16));
            end
        end
        in_valid = 1'b0;
        chk("wrap_total", 32'(n_out), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
